// File: rtl/disp_src_sched.sv
// disp_src_sched: picks one of four 16-bit debug words for the seven-segment path (manual / auto-rotate / freeze)
//   CLK          in  clock, all state on rising edge
//   Reset        in  asynchronous active-low reset
//   mode_auto    in  1 = auto-rotate, 0 = manual
//   select_sign  in  [1:0] manual source index
//   step_pulse   in  single-cycle pulse, advances source in auto mode
//   freeze       in  level, holds the current display value
//   src0..src3   in  [15:0] debug words
//   display_data out [15:0] registered selected word
//   cur_sel      out [1:0] registered active source index
//   src_led      out [3:0] one-hot of cur_sel
//   update       out one-cycle strobe when display_data first shows a new source
module disp_src_sched #(
  parameter int unsigned DWELL_CYCLES = 100000000,
  parameter int          CNT_W        = 32
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        mode_auto,
  input  logic [1:0]  select_sign,
  input  logic        step_pulse,
  input  logic        freeze,
  input  logic [15:0] src0,
  input  logic [15:0] src1,
  input  logic [15:0] src2,
  input  logic [15:0] src3,
  output logic [15:0] display_data,
  output logic [1:0]  cur_sel,
  output logic [3:0]  src_led,
  output logic        update
);
  typedef enum logic [1:0] {MANUAL, AUTO, HOLD} state_t;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DWELL_CYCLES - 1);
  state_t state_q, state_d;
  logic [1:0] sel_q, sel_d, prev_q, prev_d;
  logic [CNT_W-1:0] dwell_q, dwell_d, eff;
  logic [15:0] disp_q, disp_d, src_mux;
  logic upd_q, upd_d;
  always_ff @(posedge CLK or negedge Reset)
    if (!Reset) begin
      state_q <= MANUAL;
      sel_q   <= '0;
      prev_q  <= '0;
      dwell_q <= '0;
      disp_q  <= '0;
      upd_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      prev_q  <= prev_d;
      dwell_q <= dwell_d;
      disp_q  <= disp_d;
      upd_q   <= upd_d;
    end
  // Actions follow the state being entered this cycle, so freeze and mode changes take effect on the same edge.
  // Entering AUTO from any other state restarts the dwell count from zero.
  always_comb begin
    state_d = freeze ? HOLD : mode_auto ? AUTO : MANUAL;
    eff     = (state_q == AUTO) ? dwell_q : '0;
    src_mux = sel_q[1] ? (sel_q[0] ? src3 : src2) : (sel_q[0] ? src1 : src0);
    sel_d   = sel_q;
    dwell_d = dwell_q;
    disp_d  = disp_q;
    prev_d  = prev_q;
    upd_d   = 1'b0;
    if (state_d == MANUAL) begin
      sel_d   = select_sign;
      dwell_d = '0;
    end else if (state_d == AUTO) begin
      sel_d   = (step_pulse || eff == LAST) ? sel_q + 2'd1 : sel_q;
      dwell_d = (step_pulse || eff == LAST) ? '0 : eff + CNT_W'(1);
    end
    if (state_d != HOLD) begin
      disp_d = src_mux;
      prev_d = sel_q;
      upd_d  = sel_q != prev_q;
    end
  end
  assign display_data = disp_q;
  assign cur_sel      = sel_q;
  assign src_led      = 4'b0001 << sel_q;
  assign update       = upd_q;
endmodule
